// File: rtl/conv_deinterleaver_if.sv
// Byte-stream bundle between the upstream interleaver and the deinterleaver.
interface conv_deinterleaver_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
);
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             sync_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [SEL_W-1:0] sel;
  logic             sync_err;
  logic             primed;

  modport master (
    output data_in, in_valid, sync_in,
    input  data_out, out_valid, sel, sync_err, primed
  );

  modport slave (
    input  data_in, in_valid, sync_in,
    output data_out, out_valid, sel, sync_err, primed
  );
endinterface

// File: rtl/conv_deinterleaver.sv
// Forney convolutional deinterleaver: branch b delays (N_BRANCH-1-b)*DEPTH_M visits.
// One-cycle latency; no backpressure, every in_valid byte is accepted.
module conv_deinterleaver #(
  parameter int WIDTH    = 8,
  parameter int N_BRANCH = 12,
  parameter int DEPTH_M  = 17,
  parameter int SEL_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_deinterleaver_if.slave  bus
);
  localparam int TOTAL  = DEPTH_M * N_BRANCH * (N_BRANCH - 1) / 2;
  localparam int FILL   = N_BRANCH * (N_BRANCH - 1) * DEPTH_M;
  localparam int ADDR_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PTR_W  = $clog2((N_BRANCH - 1) * DEPTH_M + 1);
  localparam int FILL_W = $clog2(FILL + 1);

  function automatic int branch_len(input int b);
    return (N_BRANCH - 1 - b) * DEPTH_M;
  endfunction

  function automatic int branch_base(input int b);
    return DEPTH_M * (b * (N_BRANCH - 1) - (b * (b - 1)) / 2);
  endfunction

  logic [WIDTH-1:0]  mem_q [TOTAL];
  logic [PTR_W-1:0]  ptr_q [N_BRANCH];
  logic [N_BRANCH-1:0] wrapped_q;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              out_valid_q;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              sync_err_q;
  logic              primed_q, primed_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  logic [ADDR_W-1:0] base_tbl [N_BRANCH];
  logic [PTR_W-1:0]  last_tbl [N_BRANCH];

  logic [SEL_W-1:0]  br;
  logic              last_br;
  logic              resync;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  rd_dat;
  logic [PTR_W-1:0]  ptr_nxt;
  logic              ptr_wrap;

  // Constant per-branch layout of the flat delay-cell store.
  always_comb begin
    for (int i = 0; i < N_BRANCH; i++) begin
      base_tbl[i] = ADDR_W'(branch_base(i));
      last_tbl[i] = (i == N_BRANCH - 1) ? '0 : PTR_W'(branch_len(i) - 1);
    end
  end

  always_comb begin
    br       = (bus.in_valid && bus.sync_in) ? '0 : sel_q;
    resync   = bus.in_valid && bus.sync_in && (sel_q != '0);
    last_br  = (br == SEL_W'(N_BRANCH - 1));
    addr     = base_tbl[br] + ADDR_W'(ptr_q[br]);
    ptr_wrap = (ptr_q[br] == last_tbl[br]);
    ptr_nxt  = ptr_wrap ? '0 : ptr_q[br] + 1'b1;
    // A cell not yet written since reset reads as zero.
    rd_dat   = wrapped_q[br] ? mem_q[addr] : '0;

    data_out_d = data_out_q;
    sel_d      = sel_q;
    fill_d     = fill_q;
    primed_d   = primed_q;
    if (bus.in_valid) begin
      data_out_d = last_br ? bus.data_in : rd_dat;
      sel_d      = last_br ? '0 : br + 1'b1;
      if (resync) begin
        fill_d   = FILL_W'(1);
        primed_d = 1'b0;
      end else if (fill_q != FILL_W'(FILL)) begin
        fill_d = fill_q + 1'b1;
        if (fill_d == FILL_W'(FILL)) primed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      sync_err_q  <= 1'b0;
      primed_q    <= 1'b0;
      fill_q      <= '0;
      wrapped_q   <= '0;
      for (int i = 0; i < N_BRANCH; i++) ptr_q[i] <= '0;
    end else begin
      data_out_q  <= data_out_d;
      out_valid_q <= bus.in_valid;
      sel_q       <= sel_d;
      sync_err_q  <= resync;
      primed_q    <= primed_d;
      fill_q      <= fill_d;
      if (bus.in_valid && !last_br) begin
        ptr_q[br] <= ptr_nxt;
        if (ptr_wrap) wrapped_q[br] <= 1'b1;
      end
    end
  end

  // Storage has no reset; wrapped_q masks stale contents instead.
  always_ff @(posedge clk) begin
    if (!reset && bus.in_valid && !last_br) mem_q[addr] <= bus.data_in;
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel       = sel_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.primed    = primed_q;
endmodule
